audio_subpacket_packer: RTL and testbench

Consumer side of the mono 16-bit audio sample stream feeding HDMI. Accepts one-cycle sample strobes and buffers them in a small FIFO. Formats each sample as an HDMI audio sample subpacket: identical L/R 24-bit samples plus the V/U/C/P bits of the IEC 60958 subframe. Presents subpackets to the HDMI packet scheduler over a valid/ready handshake, and runs the 192-frame channel-status block counter.

---
 rtl/audio_subpacket_packer_if.sv | 28 ++
 rtl/audio_subpacket_packer.sv | 106 ++++++++++
 tb/tb_audio_subpacket_packer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/audio_subpacket_packer_if.sv
`default_nettype none
// ============================================================================
//  audio_subpacket_packer_if : sample-in / subpacket-out bus of the packer
//  Revision: 1.0
// ============================================================================
interface audio_subpacket_packer_if #(
    parameter int DEPTH = 8
);
    logic                         I_sample_valid;
    logic [15:0]                  I_sample;
    logic                         I_pkt_ready;
    logic                         O_pkt_valid;
    logic [55:0]                  O_subpacket;
    logic                         O_frame_start;
    logic                         O_overflow;
    logic [$clog2(DEPTH+1)-1:0]   O_level;

    // master = sample source plus packet scheduler; slave = the packer
    modport master (
        output I_sample_valid, I_sample, I_pkt_ready,
        input  O_pkt_valid, O_subpacket, O_frame_start, O_overflow, O_level
    );
    modport slave (
        input  I_sample_valid, I_sample, I_pkt_ready,
        output O_pkt_valid, O_subpacket, O_frame_start, O_overflow, O_level
    );
endinterface
`default_nettype wire

// File: rtl/audio_subpacket_packer.sv
`default_nettype none
// ============================================================================
//  audio_subpacket_packer : buffers mono samples and emits HDMI audio subpackets
//  Revision: 1.0
// ============================================================================
module audio_subpacket_packer #(
    parameter int          DEPTH       = 8,
    parameter bit          UNSIGNED_IN = 1'b1,
    parameter logic [39:0] CS_LOW      = 40'h0002000004
) (
    input  wire logic                I_clk,
    input  wire logic                I_reset,
    audio_subpacket_packer_if.slave  bus
);
    localparam int           AW         = $clog2(DEPTH);
    localparam int           LW         = AW + 1;
    localparam logic [191:0] CS_VEC     = {152'b0, CS_LOW};
    localparam logic [7:0]   LAST_FRAME = 8'd191;

    logic [15:0]   mem_q [DEPTH];
    logic [15:0]   mem_d [DEPTH];
    logic [LW-1:0] wr_ptr_q, wr_ptr_d;
    logic [LW-1:0] rd_ptr_q, rd_ptr_d;
    logic          valid_q, valid_d;
    logic [55:0]   pkt_q, pkt_d;
    logic          fs_q, fs_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    frame_q, frame_d;

    logic [LW-1:0] level;
    logic          empty, full, pop, wr;
    logic [15:0]   head;
    logic [23:0]   s24;
    logic          c_bit, p_bit;
    logic [3:0]    vucp;

    always_comb begin
        level    = wr_ptr_q - rd_ptr_q;
        empty    = (level == '0);
        full     = (level == LW'(DEPTH));
        pop      = !empty && (!valid_q || bus.I_pkt_ready);
        // a pop frees the slot in the same cycle, so a full FIFO can still accept
        wr       = bus.I_sample_valid && (!full || pop);

        head     = mem_q[rd_ptr_q[AW-1:0]];
        s24      = {head[15] ^ UNSIGNED_IN, head[14:0], 8'h00};
        c_bit    = CS_VEC[frame_q];
        p_bit    = ^{s24, 2'b00, c_bit};
        vucp     = {p_bit, c_bit, 2'b00};

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        valid_d  = valid_q;
        pkt_d    = pkt_q;
        fs_d     = fs_q;
        ovf_d    = ovf_q;
        frame_d  = frame_q;

        if (wr) begin
            mem_d[wr_ptr_q[AW-1:0]] = bus.I_sample;
            wr_ptr_d                = wr_ptr_q + LW'(1);
        end else if (bus.I_sample_valid) begin
            ovf_d = 1'b1;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + LW'(1);
            valid_d  = 1'b1;
            pkt_d    = {vucp, vucp, s24, s24};
            fs_d     = (frame_q == 8'd0);
            frame_d  = (frame_q == LAST_FRAME) ? 8'd0 : frame_q + 8'd1;
        end else if (valid_q && bus.I_pkt_ready) begin
            valid_d  = 1'b0;
        end
    end

    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            valid_q  <= 1'b0;
            pkt_q    <= '0;
            fs_q     <= 1'b0;
            ovf_q    <= 1'b0;
            frame_q  <= 8'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            valid_q  <= valid_d;
            pkt_q    <= pkt_d;
            fs_q     <= fs_d;
            ovf_q    <= ovf_d;
            frame_q  <= frame_d;
        end
    end

    assign bus.O_pkt_valid   = valid_q;
    assign bus.O_subpacket   = pkt_q;
    assign bus.O_frame_start = fs_q;
    assign bus.O_overflow    = ovf_q;
    assign bus.O_level       = level;
endmodule
`default_nettype wire

// File: tb/tb_audio_subpacket_packer.sv
`default_nettype none
// ============================================================================
//  tb_audio_subpacket_packer : queue-model scoreboard plus directed literals
//  Revision: 1.0
// ============================================================================
module tb_audio_subpacket_packer;
    localparam int          DEPTH       = 8;
    localparam bit          UNSIGNED_IN = 1'b1;
    localparam logic [39:0] CS_LOW      = 40'h0002000004;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    audio_subpacket_packer_if #(.DEPTH(DEPTH)) bus();

    audio_subpacket_packer #(
        .DEPTH(DEPTH), .UNSIGNED_IN(UNSIGNED_IN), .CS_LOW(CS_LOW)
    ) dut (
        .I_clk(clk), .I_reset(rst), .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // model state: samples waiting, plus the one presented to the scheduler
    logic [15:0] mq[$];
    bit          m_valid = 0;
    logic [55:0] m_pkt   = '0;
    bit          m_fs    = 0;
    bit          m_ovf   = 0;
    int          m_frame = 0;

    function automatic logic [55:0] fmt(input logic [15:0] s, input int f);
        logic [39:0] cs;
        logic [15:0] a;
        logic [23:0] s24;
        bit          c, p;
        cs  = CS_LOW;
        a   = UNSIGNED_IN ? (s ^ 16'h8000) : s;
        s24 = {a, 8'h00};
        c   = (f < 40) ? cs[f] : 1'b0;
        p   = ((($countones(s24) + int'(c)) % 2) == 1);
        return {p, c, 1'b0, 1'b0, p, c, 1'b0, 1'b0, s24, s24};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(posedge clk or posedge rst) begin : model
        bit do_pop, do_wr;
        if (rst) begin
            mq.delete();
            m_valid = 0; m_pkt = '0; m_fs = 0; m_ovf = 0; m_frame = 0;
        end else begin
            do_pop = (mq.size() > 0) && (!m_valid || bus.I_pkt_ready);
            do_wr  = bus.I_sample_valid && ((mq.size() < DEPTH) || do_pop);
            if (do_pop) begin
                m_pkt   = fmt(mq.pop_front(), m_frame);
                m_fs    = (m_frame == 0);
                m_frame = (m_frame + 1) % 192;
                m_valid = 1;
            end else if (m_valid && bus.I_pkt_ready) begin
                m_valid = 0;
            end
            if (do_wr) mq.push_back(bus.I_sample);
            else if (bus.I_sample_valid) m_ovf = 1;
        end
    end

    always @(negedge clk) begin : compare
        if (!rst) begin
            chk("pkt_valid", 64'(bus.O_pkt_valid), 64'(m_valid));
            chk("level",     64'(bus.O_level),     64'(mq.size()));
            chk("overflow",  64'(bus.O_overflow),  64'(m_ovf));
            if (m_valid) begin
                chk("subpacket",   64'(bus.O_subpacket),   64'(m_pkt));
                chk("frame_start", 64'(bus.O_frame_start), 64'(m_fs));
            end
        end
    end

    task automatic step(input bit sv, input logic [15:0] s, input bit rdy);
        bus.I_sample_valid = sv;
        bus.I_sample       = s;
        bus.I_pkt_ready    = rdy;
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 64'(bus.O_pkt_valid),   64'd0);
        chk({tag, "_pkt"},   64'(bus.O_subpacket),   64'd0);
        chk({tag, "_fs"},    64'(bus.O_frame_start), 64'd0);
        chk({tag, "_ovf"},   64'(bus.O_overflow),    64'd0);
        chk({tag, "_level"}, 64'(bus.O_level),       64'd0);
    endtask

    task automatic async_reset_pulse();
        #2 rst = 1'b1;
        #1 chk_all_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [15:0] samp [194];

    initial begin
        bus.I_sample_valid = 1'b0;
        bus.I_sample       = '0;
        bus.I_pkt_ready    = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        // idle path: valid appears two edges after the strobe is presented
        step(1'b1, 16'd0, 1'b1);
        chk("idle_not_yet", 64'(bus.O_pkt_valid), 64'd0);
        step(1'b0, 16'd0, 1'b1);
        chk("idle_valid", 64'(bus.O_pkt_valid), 64'd1);
        chk("idle_pkt",   64'(bus.O_subpacket), 64'h88_800000_800000);
        chk("idle_fs",    64'(bus.O_frame_start), 64'd1);
        step(1'b0, 16'd0, 1'b1);

        // backpressure
        step(1'b1, 16'd1000, 1'b0);
        step(1'b1, 16'd2000, 1'b0);
        step(1'b1, 16'd3000, 1'b0);
        step(1'b0, 16'd0, 1'b0);
        chk("bp_pkt",   64'(bus.O_subpacket), 64'h88_83E800_83E800);
        chk("bp_level", 64'(bus.O_level), 64'd2);
        repeat (3) step(1'b0, 16'd0, 1'b0);
        repeat (4) step(1'b0, 16'd0, 1'b1);
        chk("bp_drained", 64'(bus.O_pkt_valid), 64'd0);

        // fill to full, then pop and write in the same cycle, then overflow
        for (int i = 0; i < DEPTH + 1; i++) step(1'b1, 16'($urandom), 1'b0);
        step(1'b0, 16'd0, 1'b0);
        chk("full_level", 64'(bus.O_level), 64'(DEPTH));
        chk("full_ovf",   64'(bus.O_overflow), 64'd0);
        step(1'b1, 16'($urandom), 1'b1);
        chk("popwr_level", 64'(bus.O_level), 64'(DEPTH));
        chk("popwr_ovf",   64'(bus.O_overflow), 64'd0);
        step(1'b1, 16'($urandom), 1'b0);
        chk("drop_ovf",   64'(bus.O_overflow), 64'd1);
        chk("drop_level", 64'(bus.O_level), 64'(DEPTH));
        repeat (DEPTH + 3) step(1'b0, 16'd0, 1'b1);
        chk("sticky_ovf", 64'(bus.O_overflow), 64'd1);

        // reset mid-operation with samples buffered and valid high
        for (int i = 0; i < 4; i++) step(1'b1, 16'($urandom), 1'b0);
        async_reset_pulse();
        step(1'b1, 16'h1234, 1'b0);
        step(1'b0, 16'd0, 1'b0);
        chk("post_rst_fs", 64'(bus.O_frame_start), 64'd1);
        chk("post_rst_c",  64'(bus.O_subpacket[50]), 64'(CS_LOW[0]));
        repeat (2) step(1'b0, 16'd0, 1'b1);

        // channel-status walk over a full block plus two frames
        async_reset_pulse();
        for (int i = 0; i < 194; i++) samp[i] = 16'($urandom);
        samp[0] = 16'h8000; samp[2] = 16'h8000; samp[25] = 16'h8000; samp[192] = 16'h8000;
        for (int i = 0; i < 196; i++) begin
            if (i < 194) step(1'b1, samp[i], 1'b1);
            else         step(1'b0, 16'd0, 1'b1);
            if (i == 1)   chk("cs_f0",   {7'd0, bus.O_frame_start, bus.O_subpacket}, {7'd0, 1'b1, 56'h0});
            if (i == 3)   chk("cs_f2",   {7'd0, bus.O_frame_start, bus.O_subpacket}, {7'd0, 1'b0, 56'hCC_000000_000000});
            if (i == 26)  chk("cs_f25",  {7'd0, bus.O_frame_start, bus.O_subpacket}, {7'd0, 1'b0, 56'hCC_000000_000000});
            if (i == 193) chk("cs_f192", {7'd0, bus.O_frame_start, bus.O_subpacket}, {7'd0, 1'b1, 56'h0});
        end

        // random traffic in several load regimes
        for (int phase = 0; phase < 4; phase++) begin
            for (int i = 0; i < 700; i++) begin
                bit sv, rdy;
                case (phase)
                    0: begin sv = ($urandom_range(0, 3) == 0); rdy = 1'b1; end
                    1: begin sv = ($urandom_range(0, 1) == 0); rdy = ($urandom_range(0, 1) == 0); end
                    2: begin sv = ($urandom_range(0, 3) != 0); rdy = ($urandom_range(0, 3) == 0); end
                    default: begin sv = ($urandom_range(0, 2) == 0); rdy = ($urandom_range(0, 4) != 0); end
                endcase
                step(sv, 16'($urandom), rdy);
            end
            if (phase == 1) async_reset_pulse();
        end
        repeat (DEPTH + 3) step(1'b0, 16'd0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
